// File: rtl/mycpu_pkg.sv
// mycpu_pkg -- constants and bus types shared by the pipeline stages.
//
// Contents:
//   RESET_PC        address of the first instruction fetched after reset
//   FS_TO_DS_W      width of the IF->ID bus {pc, inst}
//   DS_TO_ES_W, ES_TO_MS_W, MS_TO_WS_W
//                   widths of the later inter-stage buses
//   NOP_INST        LoongArch NOP encoding (andi r0, r0, 0)
//   fs_to_ds_t      packed view of the IF->ID payload
//
// No ports.
package mycpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h1c00_0000;
    localparam int          FS_TO_DS_W = 64;
    localparam int          DS_TO_ES_W = 150;
    localparam int          ES_TO_MS_W = 71;
    localparam int          MS_TO_WS_W = 70;
    localparam logic [31:0] NOP_INST   = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_t;

endpackage

// File: rtl/inst_buf_reg.sv
// inst_buf_reg -- 32-bit capture register with a valid flag.
//
// Holds an instruction returned by the SRAM while the consumer is stalled,
// because the SRAM read data is only guaranteed for one cycle.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset (clears valid)
//   clear    in   drop the held word (valid <= 0)
//   capture  in   load din and set valid, ignored while already valid
//   din      in   [31:0] word to capture
//   dout     out  [31:0] held word
//   valid    out  dout holds a captured word
module inst_buf_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid
);

    // The first captured word is kept until cleared; later capture requests
    // would only see garbage from the SRAM, so they are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= 32'h0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture && !valid) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the 5-stage pipelined core.
//
// Generates the next PC (sequential or branch redirect), issues instruction
// SRAM reads, buffers the returned word across ID stalls and hands {pc, inst}
// to ID under a valid/allowin handshake.
//
// Optional feature (macro IF_ADEF_EN): misaligned fetch addresses suppress
// the SRAM read, force the instruction to zero, and add an fs_adef flag as the
// bus MSB. Without the macro the PC low bits pass through unchecked.
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous, active-high reset
//   ds_allowin       in   ID can accept an instruction this cycle
//   br_taken         in   ID redirect request (single-cycle pulse)
//   br_target        in   [31:0] redirect PC, valid with br_taken
//   fs_to_ds_valid   out  fs_to_ds_bus holds a valid instruction
//   fs_to_ds_bus     out  {pc, inst} ({adef, pc, inst} with IF_ADEF_EN)
//   inst_sram_en     out  read enable
//   inst_sram_we     out  write enable, tied to 0
//   inst_sram_addr   out  [31:0] fetch address (nextpc)
//   inst_sram_wdata  out  [31:0] write data, tied to 0
//   inst_sram_rdata  in   [31:0] read data, one cycle after the address
module if_stage #(
    parameter logic [31:0] RESET_PC   = mycpu_pkg::RESET_PC,
    parameter int          FS_TO_DS_W = mycpu_pkg::FS_TO_DS_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ds_allowin,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    output logic                  fs_to_ds_valid,
`ifdef IF_ADEF_EN
    output logic [FS_TO_DS_W:0]   fs_to_ds_bus,
`else
    output logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
`endif
    output logic                  inst_sram_en,
    output logic                  inst_sram_we,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic [31:0]           inst_sram_rdata
);

    import mycpu_pkg::*;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        br_pend;
    logic [31:0] br_pend_target;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        buf_capture;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic [31:0] raw_inst;
    logic [31:0] fs_inst;
    logic        fetch_ok;
    fs_to_ds_t   payload;

    assign to_fs_valid = ~reset;
    assign seq_pc      = fs_pc + 32'd4;
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);

    // A live redirect beats a stored one; the stored one beats sequential flow.
    always_comb begin
        nextpc = seq_pc;
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pend) begin
            nextpc = br_pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fs_allowin) begin
            fs_valid <= to_fs_valid;
            fs_pc    <= nextpc;
        end
    end

    // A redirect that arrives while IF is blocked is remembered and consumed
    // by the next fetch; a newer redirect overwrites an older pending one.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_pend        <= 1'b0;
            br_pend_target <= 32'h0;
        end else if (fs_allowin) begin
            br_pend <= 1'b0;
        end else if (br_taken) begin
            br_pend        <= 1'b1;
            br_pend_target <= br_target;
        end
    end

    assign buf_capture = fs_valid & ~ds_allowin & ~inst_buf_valid;

    inst_buf_reg u_inst_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (fs_allowin),
        .capture (buf_capture),
        .din     (inst_sram_rdata),
        .dout    (inst_buf),
        .valid   (inst_buf_valid)
    );

    assign raw_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;

`ifdef IF_ADEF_EN
    logic fs_adef;
    assign fs_adef  = (fs_pc[1:0] != 2'b00);
    assign fetch_ok = (nextpc[1:0] == 2'b00);
    assign fs_inst  = fs_adef ? 32'h0 : raw_inst;
`else
    assign fetch_ok = 1'b1;
    assign fs_inst  = raw_inst;
`endif

    assign payload.pc   = fs_pc;
    assign payload.inst = fs_inst;

`ifdef IF_ADEF_EN
    assign fs_to_ds_bus = {fs_adef, payload};
`else
    assign fs_to_ds_bus = payload;
`endif

    // The instruction held in IF is on the wrong path whenever a redirect is
    // live or pending, so it is never offered to ID.
    assign fs_to_ds_valid  = fs_valid & ~br_taken & ~br_pend;

    assign inst_sram_en    = to_fs_valid & fs_allowin & fetch_ok;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- self-checking bench for if_stage.
//
// A directed warm-up follows the fetch/stall/branch/reset scenarios, then a
// long randomized run. The reference model tracks only "which PC is in IF",
// "is IF holding something" and "is a redirect owed"; the instruction ID must
// see for a PC is always the memory word for that PC, no matter how long the
// stall or what the SRAM output does meanwhile.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
`ifdef IF_ADEF_EN
    localparam int BUS_W = 65;
`else
    localparam int BUS_W = 64;
`endif

    logic             clk;
    logic             reset;
    logic             ds_allowin;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             fs_to_ds_valid;
    logic [BUS_W-1:0] fs_to_ds_bus;
    logic             inst_sram_en;
    logic             inst_sram_we;
    logic [31:0]      inst_sram_addr;
    logic [31:0]      inst_sram_wdata;
    logic [31:0]      inst_sram_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'ha5c3_0f96;
    endfunction

    function automatic logic [BUS_W-1:0] exp_bus(input logic [31:0] pc);
`ifdef IF_ADEF_EN
        logic adef;
        adef = (pc[1:0] != 2'b00);
        return {adef, pc, adef ? 32'h0 : mem_word(pc)};
`else
        return {pc, mem_word(pc)};
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [64:0] got,
                               input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, then advance the model and the SRAM.
    task automatic applyStimulus(input logic rst, input logic allow,
                                 input logic br, input logic [31:0] tgt);
        logic        can_accept;
        logic [31:0] exp_next;
        logic        exp_out_valid;
        logic        exp_en;
        logic        en_q;
        logic [31:0] addr_q;

        @(negedge clk);
        reset      = rst;
        ds_allowin = allow;
        br_taken   = br;
        br_target  = tgt;
        #1;

        can_accept    = !m_valid || allow;
        exp_next      = br ? tgt : (m_pend ? m_tgt : m_pc + 32'd4);
        exp_out_valid = m_valid && !br && !m_pend;
        exp_en        = !rst && can_accept;
`ifdef IF_ADEF_EN
        exp_en = exp_en && (exp_next[1:0] == 2'b00);
`endif

        checkOutput("sram_en", 65'(inst_sram_en), 65'(exp_en));
        if (!rst) checkOutput("sram_addr", 65'(inst_sram_addr), 65'(exp_next));
        checkOutput("out_valid", 65'(fs_to_ds_valid), 65'(exp_out_valid));
        if (exp_out_valid) checkOutput("bus", 65'(fs_to_ds_bus), 65'(exp_bus(m_pc)));
        checkOutput("sram_we", 65'(inst_sram_we), 65'(1'b0));
        checkOutput("sram_wdata", 65'(inst_sram_wdata), 65'(32'h0));

        en_q   = inst_sram_en;
        addr_q = inst_sram_addr;

        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = RST_PC - 32'd4;
            m_pend  = 1'b0;
        end else if (can_accept) begin
            m_valid = 1'b1;
            m_pc    = exp_next;
            m_pend  = 1'b0;
        end else if (br) begin
            m_pend = 1'b1;
            m_tgt  = tgt;
        end
        #1;
        // Read data is only good for the cycle after a read; otherwise junk.
        inst_sram_rdata = en_q ? mem_word(addr_q) : $urandom();
    endtask

    function automatic logic [31:0] pick_target();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2);
        if (r == 1) return RST_PC + 32'($urandom_range(0, 1023));
        return RST_PC + 32'($urandom_range(0, 255) << 2);
    endfunction

    initial begin
        reset           = 1'b1;
        ds_allowin      = 1'b0;
        br_taken        = 1'b0;
        br_target       = 32'h0;
        inst_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        m_valid = 1'b0;
        m_pc    = RST_PC - 32'd4;
        m_pend  = 1'b0;
        m_tgt   = 32'h0;

        // Reset state, then sequential fetch 1c000000/04/08.
        applyStimulus(1, 0, 0, 32'h0);
        repeat (3) applyStimulus(0, 1, 0, 32'h0);
        // Stall with fs_pc=1c000008 while the SRAM output turns to junk.
        repeat (3) applyStimulus(0, 0, 0, 32'h0);
        repeat (2) applyStimulus(0, 1, 0, 32'h0);
        // Redirect while IF holds 1c000010 and ID accepts.
        applyStimulus(0, 1, 1, 32'h1c00_0100);
        repeat (4) applyStimulus(0, 1, 0, 32'h0);
        // Redirect while blocked, then a second redirect before release.
        applyStimulus(0, 0, 1, 32'h1c00_0100);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h1c00_0200);
        repeat (3) applyStimulus(0, 1, 0, 32'h0);
        // Reset in the middle of a buffered stall.
        repeat (3) applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        repeat (3) applyStimulus(0, 1, 0, 32'h0);
        // PC wrap-around past 32'hFFFFFFFC.
        applyStimulus(0, 1, 1, 32'hFFFF_FFF8);
        repeat (4) applyStimulus(0, 1, 0, 32'h0);
        // Misaligned redirect target.
        applyStimulus(0, 1, 1, 32'h1c00_0102);
        repeat (3) applyStimulus(0, 1, 0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 65,
                          $urandom_range(0, 99) < 15,
                          pick_target());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined LoongArch core; replaces the IF state of the multi-cycle top.
- Sits between the instruction SRAM and the decode stage (ID).
- Generates the next PC (sequential or branch redirect), issues SRAM reads, buffers the returned instruction across ID stalls, and delivers {pc, inst} to ID under a valid/allowin handshake.

Parameters:
- RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset.
- FS_TO_DS_W, 64, width of the fs_to_ds bus: {fs_pc[31:0], fs_inst[31:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  ID can accept an instruction this cycle
- br_taken  in  1  ID redirect request, single-cycle pulse
- br_target  in  32  redirect PC, valid with br_taken
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction
- fs_to_ds_bus  out  FS_TO_DS_W  {pc, inst}
- inst_sram_en  out  1  read enable
- inst_sram_we  out  1  constant 0
- inst_sram_addr  out  32  fetch address (= nextpc)
- inst_sram_wdata  out  32  constant 0
- inst_sram_rdata  in  32  read data, valid the cycle after the address is accepted

Behaviour:
- Reset values:
  - fs_valid=0
  - fs_pc=RESET_PC-4
  - inst_buf_valid=0
  - br_pend=0
  - fs_to_ds_valid=0
  - inst_sram_en=0
- Pre-IF:
  - to_fs_valid = ~reset
  - seq_pc = fs_pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0
  - nextpc priority: br_taken ? br_target : br_pend ? br_pend_target : seq_pc
- Handshake:
  - fs_ready_go=1
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin)
  - inst_sram_en = to_fs_valid & fs_allowin
  - inst_sram_addr = nextpc
- On fs_allowin:
  - fs_valid <= to_fs_valid
  - fs_pc <= nextpc
  - inst_buf_valid <= 0
  - br_pend <= 0
- Latency: an instruction is presented to ID one cycle after its address is issued; back-to-back throughput is 1/cycle.
- Instruction buffer:
  - If fs_valid & ~ds_allowin & ~inst_buf_valid, capture inst_buf <= inst_sram_rdata and set inst_buf_valid.
  - fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
  - SRAM output is not assumed stable after its first valid cycle.
- Branch cancel:
  - fs_to_ds_valid = fs_valid & ~br_taken & ~br_pend.
  - The wrong-path instruction in IF is never delivered.
- Branch while IF is blocked (br_taken & ~fs_allowin):
  - Latch br_pend <= 1 and br_pend_target <= br_target.
  - The redirect is applied at the next fs_allowin.
- Simultaneous br_taken and br_pend: br_taken wins and overwrites br_pend_target.
- Reset mid-stall clears the buffer, br_pend and fs_valid. The first fetch after reset deasserts is at RESET_PC.
- fs_to_ds_bus = {fs_pc, fs_inst}; the bus is don't-care when fs_to_ds_valid=0.

Optional Feature:
- Macro: IF_ADEF_EN.
- Defined:
  - Bus widens to FS_TO_DS_W+1, with MSB fs_adef = (fs_pc[1:0]!=0).
  - A misaligned nextpc still advances fs_pc, but inst_sram_en is forced to 0 and fs_inst is forced to 32'h0.
- Undefined:
  - Bus is exactly FS_TO_DS_W.
  - PC alignment is not checked; the low two address bits pass to the SRAM unchanged.

Decomposition:
- Shared package (mycpu_pkg) holds:
  - RESET_PC
  - FS_TO_DS_W and the DS_TO_ES/ES_TO_MS/MS_TO_WS bus widths
  - NOP encoding 32'h0340_0000
- Sub-module inst_buf_reg: 32-bit capture register with valid flag and clear. This is the only natural split; the PC logic stays inline.

Test Plan:
- Reset released, ds_allowin=1, SRAM returns the address as data -> inst_sram_addr 1c000000, 1c000004, 1c000008 on consecutive cycles; bus {1c000000,1c000000} appears one cycle after the first address.
- ds_allowin=0 for 3 cycles while fs_pc=1c000008 and the SRAM output changes to garbage after 1 cycle -> inst_sram_en=0, fs_pc holds, bus holds {1c000008, original inst}; next fetch 1c00000c on release.
- br_taken=1, br_target=1c000100 while fs_pc=1c000010 valid -> fs_to_ds_valid=0 that cycle, inst_sram_addr=1c000100, next delivered pc=1c000100.
- br_taken with ds_allowin=0 -> br_pend set, fs_to_ds_valid=0; on allowin, fetch 1c000100 and 1c000014 is never delivered.
- Assert reset during a stall with inst_buf_valid=1 -> after release, first address 1c000000, no stale buffered inst delivered.
- IF_ADEF_EN defined, br_target=1c000102 -> bus MSB=1, inst=0, inst_sram_en=0 for that fetch.
